core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Memory-side responder for the TP-ISA core. It owns the instruction store and the data store. It boots both over a byte-wide load port while holding the core in reset, then serves the core's instruction fetch (`pc` → `instr`), two data read ports (`addr[1:2]` → `rdata[1:2]`) and one write port (`wdata`, `wen`). It sits beside the core top level and connects port-for-port to its memory interface.

## Interface
Parameters:
- `width`, 8: data word width.
- `pc_width`, 8: fetch address width; IMEM depth is 2**pc_width.
- `addr_width`, 8: data address width; DMEM depth is 2**addr_width.
- `instr_width`, 16: instruction word width. Must be a multiple of 8 and equal `$bits(types::instr_t)` (elaboration-time check).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `pc`  in  pc_width: core fetch address.
- `instr`  out  instr_width (`types::instr_t`): fetched instruction.
- `addr[1:2]`  in  2×addr_width: core data addresses.
- `rdata[1:2]`  out  2×width: read data.
- `wdata`  in  width: write data.
- `wen`  in  1: write enable.
- `ld_data`  in  8: boot byte.
- `ld_valid`  in  1: boot byte valid.
- `ld_ready`  out  1: responder accepts boot byte.
- `core_reset`  out  1: reset to the core, high until boot completes.
- `boot_done`  out  1: high in RUN.
- `pc_oob`  out  1: sticky; set when a fetch hits an unloaded slot.

## Operation
- States: CLEAR → HDR → LOAD → RUN. Reset enters CLEAR from any state.
- CLEAR: a counter walks DMEM from 0 to 2**addr_width−1 and writes 0, one entry per cycle. After the last entry the FSM goes to HDR. Core `wen` is ignored.
- HDR: `ld_ready`=1. The first accepted byte k sets the instruction count N=k+1 (1..256, clipped to 2**pc_width). Next state is LOAD.
- LOAD: `ld_ready`=1. Each instruction takes B=instr_width/8 bytes, little-endian. The bytes gather in a shift register. On the B-th byte the word is written to IMEM[slot] and slot increments. When slot reaches N after that write, the FSM goes to RUN.
- A byte is accepted on a rising edge with `ld_valid`&&`ld_ready`. Gaps in `ld_valid` are allowed, and the FSM holds its state through them.
- RUN: `ld_ready`=0.
  - `instr`=IMEM[pc] if pc<N, else all-zero and `pc_oob` sets.
  - `rdata[i]`=DMEM[addr[i]], combinational.
  - `wen`=1 writes `wdata` to DMEM[addr[1]] on the rising edge.
  - RUN is left only by reset.
- Read during write to the same address returns old data in that cycle and new data from the next cycle.
- Outside RUN: `instr`=0, `rdata`=0, and writes are dropped.
- Reset mid-LOAD: N and slot clear, and the partial shift register is discarded. IMEM contents are not cleared, but every slot is unreachable until it is reloaded.

## Timing
- Values during and after reset:
  - State=CLEAR, `core_reset`=1, `boot_done`=0, `ld_ready`=0, `pc_oob`=0.
  - `instr`=0, `rdata`=0.
  - N=0, slot=0, clear counter=0.
- CLEAR lasts exactly 2**addr_width cycles after reset deasserts. `ld_ready` rises on the next edge.
- Minimum boot is 2**addr_width + 1 + N·B accepted-byte cycles.
- `core_reset` and `boot_done` are registered. Both change on the same edge that writes the last IMEM word, so the core's first un-reset cycle sees `instr`=IMEM[0] when pc=0.
- Fetch and read latency in RUN is 0 cycles (combinational). Write latency is 1 edge.
- `pc_oob` is registered and sets on the edge after the out-of-range fetch.

## Structure
- Shared package (`types`) holds:
  - the boot state enum `boot_state_t` {CLEAR, HDR, LOAD, RUN};
  - the `instr_t` alias used on `instr`.
- Sub-module `dmem_2r1w`: parameterised width/addr_width register array with two async read ports and one sync write port with enable. The clear walk shares its write port through a mux.
- IMEM, the FSM, byte assembly and counters stay in the top of the block.

## Test plan
- Reset release, then `ld_valid` held: DMEM reads 0 at addresses 0, 0x7F and 0xFF; `ld_ready` rises exactly 256 cycles after reset deassert.
- Header 0x02 and bytes 34 12 78 56 BC 9A: `instr`=0x1234 at pc=0, 0x5678 at pc=1, 0x9ABC at pc=2; `core_reset` falls on the edge of byte 0x9A.
- RUN, pc=3 with N=3: `instr`=0 and `pc_oob`=1 from the next cycle; it stays 1 after pc returns to 0.
- RUN, addr[1]=addr[2]=0x10, wdata=0xA5, wen=1: `rdata` stays 0 that cycle and reads 0xA5 on both ports the next cycle.
- `ld_valid` toggling 1/0 every cycle during LOAD: same IMEM image as the back-to-back case, and `ld_ready` is never deasserted before RUN.
- Reset asserted after 3 of 6 load bytes, then a full reload of header 0x00 with bytes EF BE: N=1, `instr`(pc=0)=0xBEEF, and `instr`(pc=1)=0 with `pc_oob`=1.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
// Shared types for the memory responder.
//   boot_state_t : boot sequencer states (CLEAR -> HDR -> LOAD -> RUN)
//   instr_t      : instruction word presented on the fetch port
package types;

    typedef enum logic [1:0] {CLEAR, HDR, LOAD, RUN} boot_state_t;

    typedef logic [15:0] instr_t;

endpackage

// File: rtl/core_mem_responder_if.sv
// Core <-> responder bus: fetch, two data reads, one write, boot byte port
// and boot status.
//   master : core / boot-loader side (drives pc, addr, wdata, wen, ld_*)
//   slave  : responder side (drives instr, rdata, ld_ready, status)
interface core_mem_responder_if
    import types::*;
#(
    parameter int width      = 8,
    parameter int pc_width   = 8,
    parameter int addr_width = 8
);
    logic [pc_width-1:0]        pc;
    instr_t                     instr;
    logic [1:2][addr_width-1:0] addr;
    logic [1:2][width-1:0]      rdata;
    logic [width-1:0]           wdata;
    logic                       wen;
    logic [7:0]                 ld_data;
    logic                       ld_valid;
    logic                       ld_ready;
    logic                       core_reset;
    logic                       boot_done;
    logic                       pc_oob;

    modport master (
        output pc, addr, wdata, wen, ld_data, ld_valid,
        input  instr, rdata, ld_ready, core_reset, boot_done, pc_oob
    );

    modport slave (
        input  pc, addr, wdata, wen, ld_data, ld_valid,
        output instr, rdata, ld_ready, core_reset, boot_done, pc_oob
    );
endinterface

// File: rtl/core_mem_responder_dmem_2r1w.sv
// Data store: register array with two asynchronous read ports and one
// synchronous write port.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : two read addresses, rdata : two combinational read results
// No reset: contents are initialised by the owner's clear walk.
module dmem_2r1w #(
    parameter int width      = 8,
    parameter int addr_width = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [addr_width-1:0]      waddr,
    input  logic [width-1:0]           wdata,
    input  logic [1:2][addr_width-1:0] raddr,
    output logic [1:2][width-1:0]      rdata
);
    logic [width-1:0] mem [2**addr_width];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar i = 1; i <= 2; i++) begin : g_rd
        assign rdata[i] = mem[raddr[i]];
    end
endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the TP-ISA core. Boots DMEM (zero fill) and
// IMEM (byte-wide little-endian load) while holding the core in reset,
// then serves fetch, two data reads and one data write.
//   clk, reset : clock, asynchronous active-high reset
//   mem        : slave side of the core/boot bus
module core_mem_responder
    import types::*;
#(
    parameter int width       = 8,
    parameter int pc_width    = 8,
    parameter int addr_width  = 8,
    parameter int instr_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    core_mem_responder_if.slave  mem
);
    localparam int B      = instr_width / 8;
    localparam int IDEPTH = 2**pc_width;

    if (instr_width % 8 != 0 || instr_width != $bits(instr_t)) begin : g_bad_width
        $error("core_mem_responder: instr_width must be a multiple of 8 and match instr_t");
    end

    // one extra bit so N can hold the full depth
    typedef logic [pc_width:0] cnt_t;

    boot_state_t             state, state_nx;
    logic [addr_width-1:0]   clr_cnt;
    cnt_t                    n, slot, n_hdr;
    logic [7:0]              bcnt;
    logic [instr_width-1:0]  sh;
    logic [instr_width+7:0]  cat;
    logic [8:0]              k1;
    instr_t                  imem [IDEPTH];
    logic                    accept, word_done, last_word, pc_hit;
    logic                    core_reset_q, boot_done_q, pc_oob_q;

    logic                        dm_we;
    logic [addr_width-1:0]       dm_waddr;
    logic [width-1:0]            dm_wdata;
    logic [1:2][width-1:0]       dm_rd;

    assign mem.ld_ready = (state == HDR) || (state == LOAD);
    assign accept       = mem.ld_valid && mem.ld_ready;

    // New byte enters at the top; after B bytes the first byte sits lowest.
    assign cat       = {mem.ld_data, sh};
    assign word_done = accept && (state == LOAD) && (bcnt == 8'(B - 1));
    assign last_word = word_done && ((slot + cnt_t'(1)) == n);

    // Header byte k gives N = k+1, clipped to the IMEM depth.
    assign k1    = {1'b0, mem.ld_data} + 9'd1;
    assign n_hdr = (int'(k1) > IDEPTH) ? cnt_t'(IDEPTH) : cnt_t'(k1);

    assign pc_hit = ({1'b0, mem.pc} < n);

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) state_nx = HDR;
            HDR:     if (accept)        state_nx = LOAD;
            LOAD:    if (last_word)     state_nx = RUN;
            RUN:                        state_nx = RUN;
            default:                    state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            n            <= '0;
            slot         <= '0;
            bcnt         <= '0;
            sh           <= '0;
            core_reset_q <= 1'b1;
            boot_done_q  <= 1'b0;
            pc_oob_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (state == HDR && accept) n <= n_hdr;
            if (state == LOAD && accept) begin
                sh   <= cat[instr_width+7:8];
                bcnt <= word_done ? 8'd0 : bcnt + 8'd1;
                if (word_done) slot <= slot + cnt_t'(1);
            end
            // registered so the core leaves reset together with the last IMEM write
            if (last_word) begin
                core_reset_q <= 1'b0;
                boot_done_q  <= 1'b1;
            end
            if (state == RUN && !pc_hit) pc_oob_q <= 1'b1;
        end
    end

    // IMEM is not reset; stale words stay unreachable because N clears.
    always_ff @(posedge clk) begin
        if (word_done) imem[slot[pc_width-1:0]] <= instr_t'(cat[instr_width+7:8]);
    end

    assign mem.instr      = (state == RUN && pc_hit) ? imem[mem.pc] : '0;
    assign mem.core_reset = core_reset_q;
    assign mem.boot_done  = boot_done_q;
    assign mem.pc_oob     = pc_oob_q;

    // The clear walk borrows the single DMEM write port.
    assign dm_we    = (state == CLEAR) || (state == RUN && mem.wen);
    assign dm_waddr = (state == CLEAR) ? clr_cnt : mem.addr[1];
    assign dm_wdata = (state == CLEAR) ? '0 : mem.wdata;

    dmem_2r1w #(.width(width), .addr_width(addr_width)) u_dmem (
        .clk   (clk),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .raddr (mem.addr),
        .rdata (dm_rd)
    );

    assign mem.rdata = (state == RUN) ? dm_rd : '0;
endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder: boot timing, image load (back to
// back and with gaps), RUN vector table, sticky pc_oob, reset mid-load.
module tb_core_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    core_mem_responder_if #(.width(8), .pc_width(8), .addr_width(8)) bus ();

    core_mem_responder #(.width(8), .pc_width(8), .addr_width(8), .instr_width(16)) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bus)
    );

    typedef struct {
        logic [7:0]  pc, a1, a2, wd;
        logic        we;
        logic [15:0] ei;
        logic [7:0]  e1, e2;
        logic        eoob;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ld_ready && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.ld_data  = b;
        bus.ld_valid = 1'b1;
        tick();
    endtask

    logic [7:0] img [6];
    int cyc;
    int bad;

    initial begin
        img[0] = 8'h34; img[1] = 8'h12; img[2] = 8'h78;
        img[3] = 8'h56; img[4] = 8'hBC; img[5] = 8'h9A;

        //            pc     a1     a2     wd     we    instr     r1     r2    oob
        vecs[0] = '{8'h00, 8'h00, 8'h7F, 8'h00, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'h01, 8'hFF, 8'h10, 8'h00, 1'b0, 16'h5678, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'h02, 8'h10, 8'h10, 8'hA5, 1'b1, 16'h9ABC, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h02, 8'h10, 8'h10, 8'h00, 1'b0, 16'h9ABC, 8'hA5, 8'hA5, 1'b0};
        vecs[4] = '{8'h03, 8'h20, 8'h10, 8'h3C, 1'b1, 16'h0000, 8'h00, 8'hA5, 1'b0};
        vecs[5] = '{8'h00, 8'h20, 8'hFF, 8'h00, 1'b0, 16'h1234, 8'h3C, 8'h00, 1'b1};
        vecs[6] = '{8'h01, 8'h11, 8'h0F, 8'h00, 1'b0, 16'h5678, 8'h00, 8'h00, 1'b1};

        reset = 1'b1;
        bus.pc = '0; bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0;
        bus.ld_data = 8'h02; bus.ld_valid = 1'b1;
        repeat (3) tick();

        // ---- reset state
        chk("rst_core_reset", bus.core_reset, 1);
        chk("rst_boot_done",  bus.boot_done,  0);
        chk("rst_ld_ready",   bus.ld_ready,   0);
        chk("rst_pc_oob",     bus.pc_oob,     0);
        chk("rst_instr",      bus.instr,      0);
        chk("rst_rdata",      bus.rdata,      0);

        // ---- CLEAR length with ld_valid held, then back-to-back load
        reset = 1'b0;
        wait_ready(cyc);
        chk("clear_len", cyc, 256);
        send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(img[i]);
        chk("core_reset_before_last", bus.core_reset, 1);
        send_byte(img[5]);
        bus.ld_valid = 1'b0;
        chk("core_reset_after_last", bus.core_reset, 0);
        chk("boot_done_after_last",  bus.boot_done,  1);
        chk("ld_ready_run",          bus.ld_ready,   0);

        // ---- RUN vector table
        for (int i = 0; i < 7; i++) begin
            bus.pc = vecs[i].pc; bus.addr[1] = vecs[i].a1; bus.addr[2] = vecs[i].a2;
            bus.wdata = vecs[i].wd; bus.wen = vecs[i].we;
            #1;
            chk($sformatf("vec%0d_instr", i),  bus.instr,    vecs[i].ei);
            chk($sformatf("vec%0d_rdata1", i), bus.rdata[1], vecs[i].e1);
            chk($sformatf("vec%0d_rdata2", i), bus.rdata[2], vecs[i].e2);
            chk($sformatf("vec%0d_pc_oob", i), bus.pc_oob,   vecs[i].eoob);
            tick();
        end
        bus.wen = 1'b0;

        // ---- reboot with ld_valid toggling every cycle
        reset = 1'b1;
        #1;
        chk("reboot_pc_oob_clr", bus.pc_oob, 0);
        chk("reboot_core_reset", bus.core_reset, 1);
        tick();
        reset = 1'b0;
        wait_ready(cyc);
        chk("clear_len_2", cyc, 256);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            send_byte(i == 0 ? 8'h02 : img[i-1]);
            if (i < 6) begin
                bus.ld_valid = 1'b0;
                if (!bus.ld_ready) bad++;
                tick();
                if (!bus.ld_ready) bad++;
            end
        end
        bus.ld_valid = 1'b0;
        chk("gap_ld_ready_held", bad, 0);
        chk("gap_boot_done", bus.boot_done, 1);
        bus.pc = 8'h00; #1; chk("gap_instr0", bus.instr, 16'h1234);
        bus.pc = 8'h01; #1; chk("gap_instr1", bus.instr, 16'h5678);
        bus.pc = 8'h02; #1; chk("gap_instr2", bus.instr, 16'h9ABC);
        bus.addr[1] = 8'h10; bus.addr[2] = 8'h20; #1;
        chk("gap_dmem_cleared1", bus.rdata[1], 0);
        chk("gap_dmem_cleared2", bus.rdata[2], 0);
        tick();
        chk("gap_pc_oob", bus.pc_oob, 0);

        // ---- reset after 3 of 6 load bytes, then reload one instruction
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(cyc);
        chk("clear_len_3", cyc, 256);
        send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midload_ld_ready", bus.ld_ready, 0);
        chk("midload_core_reset", bus.core_reset, 1);
        tick();
        reset = 1'b0;
        wait_ready(cyc);
        chk("clear_len_4", cyc, 256);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);
        bus.ld_valid = 1'b0;
        chk("reload_boot_done", bus.boot_done, 1);
        bus.pc = 8'h00; #1;
        chk("reload_instr0", bus.instr, 16'hBEEF);
        chk("reload_pc_oob_pre", bus.pc_oob, 0);
        bus.pc = 8'h01; #1;
        chk("reload_instr1", bus.instr, 16'h0000);
        tick();
        chk("reload_pc_oob", bus.pc_oob, 1);
        bus.pc = 8'h00; tick();
        chk("reload_pc_oob_sticky", bus.pc_oob, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
